// File: rtl/muldiv_exu.sv
// muldiv_exu: multi-cycle integer multiply/divide execution unit.
// Multiplies are computed combinationally from latched operands and are
// released after a fixed latency. Divides use a radix-2 restoring loop
// on operand magnitudes, followed by one sign-fix cycle.
//
// Handshake: an issue is accepted on a rising edge where ex_out_valid and
// ex_ready are both high and ex_kill is low. ex_ready is high only in IDLE.
// Completion is a single-cycle ex_in_valid strobe. While the strobe is high,
// ex_result and ex_exception carry the new values; otherwise they hold the
// values from the last completion. A kill during DONE suppresses the strobe
// and leaves the held values untouched.
module muldiv_exu #(
  parameter int XLEN     = 32,
  parameter int MUL_LAT  = 4,
  parameter int DIV_FAST = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_out_valid,
  input  logic [7:0]      ex_sig,
  input  logic [XLEN-1:0] ex_src1,
  input  logic [XLEN-1:0] ex_src2,
  input  logic            ex_kill,
  output logic            ex_ready,
  output logic [XLEN-1:0] ex_result,
  output logic [2:0]      ex_exception,
  output logic            ex_in_valid,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam int CW = 7;

  state_t state, state_nx;

  logic [CW-1:0]   cnt;
  logic [7:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] qq, rq, dq;
  logic            fast_q;
  logic [XLEN-1:0] res_q, out_res;
  logic [2:0]      exc_q, out_exc;

  // Decode of the incoming issue.
  logic accept, in_onehot, in_mul, in_sdiv, in_zero, in_ovf;
  assign accept    = ex_out_valid && ex_ready && !ex_kill;
  assign in_onehot = (ex_sig != 8'h00) && ((ex_sig & (ex_sig - 8'h01)) == 8'h00);
  assign in_mul    = |ex_sig[3:0];
  assign in_sdiv   = ex_sig[4] | ex_sig[6];
  assign in_zero   = (ex_src2 == '0);
  assign in_ovf    = in_sdiv && (ex_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (ex_src2 == '1);

  // Decode of the latched operation.
  logic op_legal_q, op_mul_q, sdiv_q, is_rem_q;
  assign op_legal_q = (op_q != 8'h00) && ((op_q & (op_q - 8'h01)) == 8'h00);
  assign op_mul_q   = |op_q[3:0];
  assign sdiv_q     = op_q[4] | op_q[6];
  assign is_rem_q   = op_q[6] | op_q[7];

  // Full-width product; the extension of each operand selects the signedness.
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic              a_sgn, b_sgn;
  assign a_sgn = op_q[1] | op_q[2];
  assign b_sgn = op_q[1];
  assign ext_a = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
  assign ext_b = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  // One restoring-divide step: shift in the next dividend bit, trial-subtract.
  logic [XLEN:0]   sh;
  logic [XLEN+1:0] tr;
  assign sh = {rq, qq[XLEN-1]};
  assign tr = {1'b0, sh} - {2'b00, dq};

  // Sign fix applied after the magnitude loop.
  logic            neg_q, neg_r;
  logic [XLEN-1:0] qfix, rfix;
  assign neg_q = sdiv_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign neg_r = sdiv_q & a_q[XLEN-1];
  assign qfix  = neg_q ? ('0 - qq) : qq;
  assign rfix  = neg_r ? ('0 - rq) : rq;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; kill returns any busy state to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!in_onehot)         state_nx = S_DONE;
          else if (in_mul)        state_nx = (MUL_LAT == 1) ? S_DONE : S_MUL;
          else                    state_nx = S_DIV;
        end
      end
      S_MUL: begin
        if (ex_kill)                          state_nx = S_IDLE;
        else if (cnt == CW'(MUL_LAT - 2))     state_nx = S_DONE;
      end
      S_DIV: begin
        if (ex_kill)                          state_nx = S_IDLE;
        else if (fast_q || cnt == CW'(XLEN))  state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latches, latency counter and divide datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      qq     <= '0;
      rq     <= '0;
      dq     <= '0;
      fast_q <= 1'b0;
      res_q  <= '0;
      exc_q  <= '0;
    end else if (accept) begin
      op_q   <= ex_sig;
      a_q    <= ex_src1;
      b_q    <= ex_src2;
      cnt    <= '0;
      qq     <= (in_sdiv && ex_src1[XLEN-1]) ? ('0 - ex_src1) : ex_src1;
      rq     <= '0;
      dq     <= (in_sdiv && ex_src2[XLEN-1]) ? ('0 - ex_src2) : ex_src2;
      fast_q <= (DIV_FAST != 0) && (in_zero || in_ovf);
    end else if (state == S_MUL) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
    end else if (state == S_DIV && !ex_kill) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
      if (fast_q || cnt == CW'(XLEN)) begin
        if (b_q == '0) begin
          res_q <= is_rem_q ? a_q : '1;
          exc_q <= 3'b001;
        end else if (fast_q) begin
          res_q <= is_rem_q ? '0 : a_q;
          exc_q <= 3'b000;
        end else begin
          res_q <= is_rem_q ? rfix : qfix;
          exc_q <= 3'b000;
        end
      end else if (!tr[XLEN+1]) begin
        rq <= tr[XLEN-1:0];
        qq <= {qq[XLEN-2:0], 1'b1};
      end else begin
        rq <= sh[XLEN-1:0];
        qq <= {qq[XLEN-2:0], 1'b0};
      end
    end
  end

  // Value presented on completion, selected by the latched operation.
  logic [XLEN-1:0] done_res;
  logic [2:0]      done_exc;
  always_comb begin
    done_res = '0;
    done_exc = 3'b000;
    if (!op_legal_q) begin
      done_exc = 3'b010;
    end else if (op_mul_q) begin
      done_res = op_q[0] ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      done_res = res_q;
      done_exc = exc_q;
    end
  end

  // Held result and exception, updated only on a completion strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_res <= '0;
      out_exc <= '0;
    end else if (ex_in_valid) begin
      out_res <= done_res;
      out_exc <= done_exc;
    end
  end

  assign ex_ready     = (state == S_IDLE);
  assign ex_in_valid  = (state == S_DONE) && !ex_kill;
  assign ex_result    = ex_in_valid ? done_res : out_res;
  assign ex_exception = ex_in_valid ? done_exc : out_exc;
  assign dbg_state    = state;

endmodule

// File: tb/tb_muldiv_exu.sv
// tb_muldiv_exu: randomized and directed checks of muldiv_exu against an
// arithmetic reference model (XLEN=32, MUL_LAT=4, DIV_FAST=1).
module tb_muldiv_exu;

  localparam int XLEN = 32;
  localparam int MUL_LAT = 4;

  logic            clk;
  logic            rstn;
  logic            ex_out_valid;
  logic [7:0]      ex_sig;
  logic [XLEN-1:0] ex_src1, ex_src2;
  logic            ex_kill;
  logic            ex_ready;
  logic [XLEN-1:0] ex_result;
  logic [2:0]      ex_exception;
  logic            ex_in_valid;
  logic [1:0]      dbg_state;

  int checks = 0;
  int failures = 0;
  logic [34:0] exp_q[$];
  logic [34:0] last_exp;

  muldiv_exu #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .DIV_FAST(1)) dut (
    .clk(clk), .rstn(rstn), .ex_out_valid(ex_out_valid), .ex_sig(ex_sig),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_kill(ex_kill),
    .ex_ready(ex_ready), .ex_result(ex_result), .ex_exception(ex_exception),
    .ex_in_valid(ex_in_valid), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result {exception, result} from the arithmetic definitions.
  function automatic logic [34:0] model(input logic [7:0] sig, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    logic [31:0] r;
    logic [2:0]  e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0;
    e = 3'b000;
    if ($countones(sig) != 1) begin
      e = 3'b010;
    end else if (sig[0]) begin
      p = {32'h0, a} * {32'h0, b};
      r = p[31:0];
    end else if (sig[1]) begin
      p = sa * sb;
      r = p[63:32];
    end else if (sig[2]) begin
      p = sa * longint'({32'h0, b});
      r = p[63:32];
    end else if (sig[3]) begin
      p = {32'h0, a} * {32'h0, b};
      r = p[63:32];
    end else if (b == 32'h0) begin
      e = 3'b001;
      r = (sig[4] || sig[5]) ? 32'hFFFF_FFFF : a;
    end else if (sig[4] || sig[6]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r = sig[4] ? a : 32'h0;
      end else begin
        sq = sa / sb;
        sr = sa % sb;
        r = sig[4] ? sq[31:0] : sr[31:0];
      end
    end else begin
      r = sig[5] ? (a / b) : (a % b);
    end
    return {e, r};
  endfunction

  function automatic int model_lat(input logic [7:0] sig, input logic [31:0] a, input logic [31:0] b);
    if ($countones(sig) != 1) return 1;
    if (|sig[3:0]) return MUL_LAT;
    if (b == 32'h0) return 2;
    if ((sig[4] || sig[6]) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic do_op(input string tag, input logic [7:0] sig, input logic [31:0] a,
                       input logic [31:0] b, input bit poke);
    logic [34:0] e;
    int n, lat;
    logic [31:0] got_res;
    logic [2:0]  got_exc;
    exp_q.push_back(model(sig, a, b));
    check({tag, "_ready"}, 64'(ex_ready), 64'd1);
    ex_out_valid = 1'b1; ex_sig = sig; ex_src1 = a; ex_src2 = b;
    n = 0; lat = -1; got_res = '0; got_exc = '0;
    while (lat < 0 && n < 80) begin
      @(negedge clk);
      n++;
      if (ex_in_valid) begin
        lat = n; got_res = ex_result; got_exc = ex_exception;
      end
      if (poke && n == 2 && lat < 0) begin
        ex_out_valid = 1'b1; ex_sig = 8'h01; ex_src1 = 32'h1234; ex_src2 = 32'h7;
      end else begin
        ex_out_valid = 1'b0;
      end
    end
    e = exp_q.pop_front();
    check({tag, "_lat"}, 64'(lat), 64'(model_lat(sig, a, b)));
    check({tag, "_res"}, 64'(got_res), 64'(e[31:0]));
    check({tag, "_exc"}, 64'(got_exc), 64'(e[34:32]));
    last_exp = e;
    @(negedge clk);
    check({tag, "_ready_after"}, 64'({ex_ready, ex_in_valid}), 64'b10);
  endtask

  // Counts completion strobes over a window; none are allowed.
  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ex_in_valid) seen++;
    end
    check({tag, "_no_strobe"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [7:0]  rs;
    logic [31:0] ra, rb;
    int r;
    rstn = 1'b0; ex_out_valid = 1'b0; ex_sig = '0; ex_src1 = '0; ex_src2 = '0; ex_kill = 1'b0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_ready", 64'(ex_ready), 64'd1);
    check("reset_valid", 64'(ex_in_valid), 64'd0);
    check("reset_result", 64'(ex_result), 64'd0);
    check("reset_exc", 64'(ex_exception), 64'd0);

    do_op("mulh_min", 8'h02, 32'h8000_0000, 32'h8000_0000, 1'b1);
    do_op("mulhsu_ones", 8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("mul_ones", 8'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("div_m7_2", 8'h10, 32'hFFFF_FFF9, 32'h2, 1'b1);
    do_op("rem_m7_2", 8'h40, 32'hFFFF_FFF9, 32'h2, 1'b0);
    do_op("divu_by0", 8'h20, 32'h5, 32'h0, 1'b0);
    do_op("rem_by0", 8'h40, 32'hFFFF_FFF9, 32'h0, 1'b0);
    do_op("div_ovf", 8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("rem_ovf", 8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("illegal_03", 8'h03, 32'h11, 32'h22, 1'b0);
    do_op("illegal_00", 8'h00, 32'h11, 32'h22, 1'b0);
    do_op("mulhu_big", 8'h08, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);

    // Kill a divu mid-flight: no completion, held outputs unchanged.
    ex_out_valid = 1'b1; ex_sig = 8'h20; ex_src1 = 32'd1000; ex_src2 = 32'd7;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      ex_out_valid = 1'b0;
      if (n == 10) ex_kill = 1'b1;
    end
    @(negedge clk);
    ex_kill = 1'b0;
    check("kill_idle", 64'(ex_ready), 64'd1);
    quiet("kill", 40);
    check("kill_res_held", 64'(ex_result), 64'(last_exp[31:0]));
    check("kill_exc_held", 64'(ex_exception), 64'(last_exp[34:32]));
    do_op("mul_3x5", 8'h01, 32'd3, 32'd5, 1'b0);

    // Kill coincident with an issue drops the issue.
    ex_out_valid = 1'b1; ex_kill = 1'b1; ex_sig = 8'h01; ex_src1 = 32'd9; ex_src2 = 32'd9;
    @(negedge clk);
    ex_out_valid = 1'b0; ex_kill = 1'b0;
    check("kill_accept_ready", 64'(ex_ready), 64'd1);
    quiet("kill_accept", 10);
    check("kill_accept_res", 64'(ex_result), 64'(last_exp[31:0]));

    // Asynchronous reset in the middle of a divide.
    ex_out_valid = 1'b1; ex_sig = 8'h10; ex_src1 = 32'd12345; ex_src2 = 32'd17;
    @(negedge clk);
    ex_out_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check("rst_async_ready", 64'(ex_ready), 64'd1);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_mid_result", 64'(ex_result), 64'd0);
    check("rst_mid_exc", 64'(ex_exception), 64'd0);
    quiet("rst_mid", 40);
    last_exp = '0;

    // Randomized operations.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) rs = 8'h01 << r;
      else       rs = 8'($urandom_range(0, 255));
      ra = rnd_val();
      rb = rnd_val();
      do_op($sformatf("rnd%0d_sig%02h", i, rs), rs, ra, rb, 1'($urandom_range(0, 1)));
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
